// File: rtl/disk_nibble_reader_if.sv
// Handshake bundle between the disk read path (slave) and the drive/CPU side (master).
interface disk_nibble_reader_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  enable;
   logic                  rd_pulse;
   logic                  rd_ack;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  data_valid;
   logic                  overrun;
   logic                  sync_lock;

   modport master (
      output enable, rd_pulse, rd_ack,
      input  data_out, data_valid, overrun, sync_lock
   );

   modport slave (
      input  enable, rd_pulse, rd_ack,
      output data_out, data_valid, overrun, sync_lock
   );
endinterface

// File: rtl/disk_nibble_reader.sv
// Read-side serial-to-parallel path: bit-cell recovery, self-syncing shifter and CPU data latch.
// Define DISK_SYNC_DETECT_EN to add sync_lock after SYNC_COUNT consecutive all-ones nibbles.
module disk_nibble_reader #(
   parameter int DATA_WIDTH  = 8,
   parameter int CELL_CYCLES = 28,
   parameter int SYNC_COUNT  = 4
) (
   input  logic                Clk,
   input  logic                Reset,
   disk_nibble_reader_if.slave bus
);
   localparam int              CntW     = $clog2(CELL_CYCLES);
   localparam logic [CntW-1:0] CellLast = CntW'(CELL_CYCLES - 1);
   localparam logic [CntW-1:0] CellHalf = CntW'(CELL_CYCLES / 2);

   if (CELL_CYCLES < 4 || (CELL_CYCLES % 2) != 0 || SYNC_COUNT < 1) begin : g_bad_cfg
      $error("disk_nibble_reader: CELL_CYCLES must be even and >= 4, SYNC_COUNT >= 1");
   end

   logic [CntW-1:0]       cell_cnt;
   logic                  one_pending;
   logic [DATA_WIDTH-1:0] shreg;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  valid_q;
   logic                  overrun_q;

   logic                  cell_end;
   logic                  shift_en;
   logic                  complete;
   logic [DATA_WIDTH-1:0] shift_next;

   // A pulse on the cell-end cycle re-centres the cell instead of shifting.
   always_comb begin
      cell_end   = (cell_cnt == CellLast);
      shift_en   = bus.enable && cell_end && !bus.rd_pulse;
      shift_next = {shreg[DATA_WIDTH-2:0], one_pending};
      complete   = shift_en && shift_next[DATA_WIDTH-1];
   end

   // NOTE: state is written only with non-blocking assignments so every register
   // samples the pre-edge values, independent of block ordering.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         cell_cnt    <= '0;
         one_pending <= 1'b0;
         shreg       <= '0;
      end else if (!bus.enable) begin
         cell_cnt    <= '0;
         one_pending <= 1'b0;
         shreg       <= '0;
      end else if (bus.rd_pulse) begin
         cell_cnt    <= CellHalf;
         one_pending <= 1'b1;
      end else if (cell_end) begin
         cell_cnt    <= '0;
         one_pending <= 1'b0;
         shreg       <= complete ? '0 : shift_next;
      end else begin
         cell_cnt    <= cell_cnt + 1'b1;
      end
   end

   // Data latch survives enable=0 so the CPU can still collect the last nibble.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         data_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         if (complete) begin
            data_q  <= shift_next;
            valid_q <= 1'b1;
         end else if (bus.rd_ack) begin
            valid_q <= 1'b0;
         end
         if (complete && valid_q && !bus.rd_ack) overrun_q <= 1'b1;
      end
   end

   assign bus.data_out   = data_q;
   assign bus.data_valid = valid_q;
   assign bus.overrun    = overrun_q;

`ifdef DISK_SYNC_DETECT_EN
   localparam int              RunW   = $clog2(SYNC_COUNT + 1);
   localparam logic [RunW-1:0] RunMax = RunW'(SYNC_COUNT);

   logic [RunW-1:0] ff_run;
   logic [RunW-1:0] ff_run_next;
   logic            sync_q;

   always_comb begin
      // NOTE: default first so no path through this block leaves ff_run_next unassigned
      // (which would infer a latch).
      ff_run_next = '0;
      if (&shift_next) ff_run_next = (ff_run == RunMax) ? RunMax : ff_run + 1'b1;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         ff_run <= '0;
         sync_q <= 1'b0;
      end else if (!bus.enable) begin
         ff_run <= '0;
         sync_q <= 1'b0;
      end else if (complete) begin
         ff_run <= ff_run_next;
         sync_q <= (ff_run_next == RunMax);
      end
   end

   assign bus.sync_lock = sync_q;
`else
   assign bus.sync_lock = 1'b0;
`endif
endmodule

// File: tb/tb_disk_nibble_reader.sv
// Scoreboard bench for disk_nibble_reader: randomised pulse streams against a byte-level model.
module tb_disk_nibble_reader;
   localparam int DW   = 8;
   localparam int CC   = 28;
   localparam int HALF = CC / 2;
   localparam int SC   = 4;
`ifdef DISK_SYNC_DETECT_EN
   localparam bit SYNC_ON = 1'b1;
`else
   localparam bit SYNC_ON = 1'b0;
`endif

   typedef struct {
      logic [DW-1:0] data;
      logic          ovr;
      logic          sync;
      int            edge_c;
   } exp_t;

   logic Clk = 1'b0;
   logic Reset;
   int   edge_n = 0;
   int   n_checks = 0;
   int   n_err = 0;

   exp_t sb[$];
   exp_t mon_e;
   logic m_valid;
   logic m_ovr;
   int   m_run;

   disk_nibble_reader_if #(.DATA_WIDTH(DW)) bus ();

   disk_nibble_reader #(
      .DATA_WIDTH (DW),
      .CELL_CYCLES(CC),
      .SYNC_COUNT (SC)
   ) dut (
      .Clk  (Clk),
      .Reset(Reset),
      .bus  (bus)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) edge_n <= edge_n + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: a new nibble is presented when data_valid rises or data_out changes while valid.
   logic          prev_valid;
   logic [DW-1:0] prev_data;
   always @(negedge Clk) begin
      if (Reset) begin
         prev_valid = 1'b0;
         prev_data  = '0;
      end else begin
         if (bus.data_valid && (!prev_valid || bus.data_out != prev_data)) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL unexpected_nibble: got 0x%0h, expected none", bus.data_out);
            end else begin
               mon_e = sb.pop_front();
               check("data_out", bus.data_out, mon_e.data);
               check("overrun", bus.overrun, mon_e.ovr);
               check("sync_lock", bus.sync_lock, mon_e.sync);
               check("latency_edge", edge_n, mon_e.edge_c);
            end
         end
         prev_valid = bus.data_valid;
         prev_data  = bus.data_out;
      end
   end

   // Drive pulses/acks on absolute edge numbers; optionally verify the ack clears data_valid.
   task automatic run_edges(input int pe[$], input int ack_e, input int end_e, input bit chk_ack);
      int e;
      do begin
         @(negedge Clk);
         e = edge_n + 1;
         if (chk_ack && e == ack_e) check("valid_before_ack", bus.data_valid, 1);
         if (chk_ack && e == ack_e + 1) check("valid_after_ack", bus.data_valid, 0);
         bus.rd_pulse = (pe.size() > 0 && pe[0] == e);
         if (bus.rd_pulse) void'(pe.pop_front());
         bus.rd_ack = (e == ack_e);
      end while (e < end_e);
   endtask

   // ack_mode: 0 = never, 1 = on the completion edge, 2 = three edges after completion.
   task automatic send_byte(input logic [DW-1:0] val, input int first_edge, input int amp,
                            input int ack_mode);
      int   pe[$];
      int   g, j, jprev, last_i, c, ack_e;
      exp_t ex;
      g      = (first_edge > 0) ? first_edge : edge_n + 6;
      jprev  = 0;
      last_i = 0;
      for (int i = 0; i < DW; i++) begin
         if (val[DW-1-i]) begin
            j = (i == 0) ? 0 : int'($urandom_range(2 * amp)) - amp;
            if (j - jprev <= -HALF) j = jprev - HALF + 1;
            pe.push_back(g + CC * i + j);
            jprev  = j;
            last_i = i;
         end
      end
      // Each 1 shifts HALF edges after its pulse; trailing zeros follow at full-cell spacing.
      c = pe[pe.size()-1] + HALF + CC * (DW - 1 - last_i);
      if (m_valid && ack_mode != 1) m_ovr = 1'b1;
      m_valid = (ack_mode != 2);
      m_run   = (val == '1) ? ((m_run < SC) ? m_run + 1 : SC) : 0;
      ex.data   = val;
      ex.ovr    = m_ovr;
      ex.sync   = SYNC_ON && (m_run == SC);
      ex.edge_c = c;
      sb.push_back(ex);
      ack_e = (ack_mode == 1) ? c : (ack_mode == 2) ? c + 3 : -1;
      run_edges(pe, ack_e, c + 5, ack_mode == 2);
      check("nibble_presented", sb.size(), 0);
   endtask

   task automatic send_bits(input logic [DW-1:0] val, input int nbits);
      int pe[$];
      int g;
      g = edge_n + 6;
      for (int i = 0; i < nbits; i++)
         if (val[DW-1-i]) pe.push_back(g + CC * i);
      run_edges(pe, -1, pe[pe.size()-1] + 3, 1'b0);
   endtask

   task automatic ack_pulse();
      @(negedge Clk);
      bus.rd_ack = 1'b1;
      @(negedge Clk);
      bus.rd_ack = 1'b0;
      check("ack_clears_valid", bus.data_valid, 0);
      m_valid = 1'b0;
   endtask

   task automatic set_enable(input logic v);
      @(negedge Clk);
      bus.enable = v;
      if (!v) m_run = 0;
   endtask

   task automatic do_reset();
      @(negedge Clk);
      #2 Reset = 1'b1;
      #1;
      check("rst_data_out", bus.data_out, 0);
      check("rst_data_valid", bus.data_valid, 0);
      check("rst_overrun", bus.overrun, 0);
      check("rst_sync_lock", bus.sync_lock, 0);
      check("sb_empty_at_reset", sb.size(), 0);
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_run   = 0;
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] val;
      logic [DW-1:0] last_val;
      int            k;
      Reset        = 1'b1;
      bus.enable   = 1'b1;
      bus.rd_pulse = 1'b0;
      bus.rd_ack   = 1'b0;
      m_valid      = 1'b0;
      m_ovr        = 1'b0;
      m_run        = 0;
      repeat (3) @(negedge Clk);
      check("init_data_out", bus.data_out, 0);
      check("init_data_valid", bus.data_valid, 0);
      check("init_overrun", bus.overrun, 0);
      check("init_sync_lock", bus.sync_lock, 0);
      Reset = 1'b0;

      // Centred 0xD5 after three empty cells, acked afterwards.
      send_byte(8'hD5, edge_n + 3 * CC + HALF, 0, 2);

      // Back-to-back without ack raises overrun; then ack on the completion cycle avoids it.
      send_byte(8'hD5, 0, 0, 0);
      send_byte(8'hAA, 0, 0, 0);
      ack_pulse();
      do_reset();
      send_byte(8'hD5, 0, 0, 0);
      send_byte(8'hAA, 0, 0, 1);
      ack_pulse();

      // Jittered pulses, then a first pulse landing exactly on a cell-end cycle.
      send_byte(8'h96, 0, CC / 4, 2);
      set_enable(1'b0);
      repeat (3) @(negedge Clk);
      bus.enable = 1'b1;
      k = edge_n + 1;
      send_byte(8'hB1, k + CC - 1, 0, 2);

      // Partial nibble flushed by enable=0; latched data retained meanwhile.
      send_byte(8'hC3, 0, 3, 0);
      send_bits(8'hFF, 4);
      set_enable(1'b0);
      repeat (10) @(negedge Clk);
      check("hold_data_out", bus.data_out, 8'hC3);
      check("hold_data_valid", bus.data_valid, 1);
      check("hold_sync_lock", bus.sync_lock, 0);
      set_enable(1'b1);
      send_byte(8'hB7, 0, 3, 1);
      ack_pulse();

      // Sync run: five all-ones nibbles then a data nibble.
      repeat (5) send_byte(8'hFF, 0, 2, 2);
      send_byte(8'hD5, 0, 2, 2);

      // Random bytes, jitter and ack timing.
      last_val = 8'hD5;
      for (int n = 0; n < 16; n++) begin
         val = DW'($urandom) | 8'h80;
         if (val == last_val) val ^= 8'h01;
         send_byte(val, 0, int'($urandom_range(CC / 4)), int'($urandom_range(2)));
         last_val = val;
      end

      // Asynchronous reset in the middle of a nibble, then a clean decode.
      send_byte((last_val == 8'h9C) ? 8'h9D : 8'h9C, 0, 2, 0);
      send_bits(8'hE9, 5);
      do_reset();
      send_byte(8'hA5, 0, 4, 2);

      repeat (5) @(negedge Clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/disk_nibble_reader.md
Name: disk_nibble_reader

Overview:
Read-side serial-to-parallel path for the disk controller. It recovers bit cells from single-cycle raw read pulses and shifts them into an 8-bit register. Leading zeros are discarded (self-sync), and a nibble is complete when the MSB sets. Completed nibbles go to a data latch that the CPU read logic polls through a valid/ack handshake. This is the receive counterpart of the parallel-load/serial-out write shifter.

Parameters:
DATA_WIDTH, 8, nibble width in bits; MSB=1 marks completion.
CELL_CYCLES, 28, Clk cycles per bit cell; even, >=4.
SYNC_COUNT, 4, consecutive all-ones nibbles needed for sync_lock (optional feature only).

Ports:
Clk  input  1  system clock, all state on rising edge.
Reset  input  1  asynchronous, active-high reset.
enable  input  1  drive motor on / read mode; low = idle and flush.
rd_pulse  input  1  single-cycle flux pulse, already synchronised to Clk.
rd_ack  input  1  single-cycle strobe: CPU consumed data_out.
data_out  output  DATA_WIDTH  last completed nibble.
data_valid  output  1  data_out holds an unconsumed nibble.
overrun  output  1  sticky: a nibble completed while data_valid=1.
sync_lock  output  1  SYNC_COUNT consecutive all-ones nibbles seen (optional feature).

Behaviour:
- Reset (async, any time including mid-nibble) clears:
  - Outputs: data_out=0, data_valid=0, overrun=0, sync_lock=0.
  - Internal: cell_cnt=0, one_pending=0, shreg=0, ff_run=0.
- enable=0 (synchronous, checked each cycle): cell_cnt=0, one_pending=0, shreg=0, ff_run=0, sync_lock=0.
  - data_out, data_valid, overrun are retained; rd_ack still clears data_valid.
- Bit-cell timer (enable=1):
  - cell_cnt counts 0..CELL_CYCLES-1.
  - Cell end (cell_cnt==CELL_CYCLES-1): shift bit b=one_pending; clear one_pending; cell_cnt=0.
  - rd_pulse: set one_pending; cell_cnt=CELL_CYCLES/2. A pulse is nominally mid-cell, so the cell end follows CELL_CYCLES/2-1 cycles later. Repeated pulses keep re-centring.
  - rd_pulse on the cell-end cycle: the pulse wins. cell_cnt=CELL_CYCLES/2, one_pending=1, no shift that cycle.
  - No pulses: a 0 is shifted every CELL_CYCLES cycles.
- Shift rule on cell end: next = {shreg[DATA_WIDTH-2:0], b}.
  - shreg==0 and b==0: stays 0 (leading zeros ignored).
  - next[DATA_WIDTH-1]==1: completion. data_out<=next, data_valid<=1, shreg<=0 in the same cycle.
  - Otherwise shreg<=next.
- Handshake:
  - rd_ack with data_valid=1 clears data_valid next cycle.
  - rd_ack with data_valid=0 is ignored.
  - Completion while data_valid=1 and no rd_ack that cycle: overwrite data_out, data_valid stays 1, overrun<=1.
  - Completion and rd_ack in the same cycle: new data, data_valid=1, no overrun.
  - overrun clears only on Reset.
- Latency: a completing nibble is visible on data_out/data_valid one Clk after its cell-end edge.

Optional Feature:
Macro DISK_SYNC_DETECT_EN.
- Defined:
  - On each completion, ff_run increments (saturating at SYNC_COUNT) if the nibble is all-ones; otherwise ff_run=0.
  - sync_lock = (ff_run==SYNC_COUNT), registered, updated on the same cycle as data_valid.
  - ff_run and sync_lock clear on Reset and on enable=0.
- Undefined: ff_run is absent and sync_lock is tied to 0.

Test Plan:
- Reset mid-nibble: drive 5 bits, assert Reset -> all outputs 0 immediately (async); after release, next nibble decodes cleanly.
- Stream 0xD5 (pulses centred in cells), preceded by 3 zero cells -> data_out=0xD5, data_valid=1 one Clk after 8th 1-bearing cell end; rd_ack -> data_valid=0 next cycle.
- Stream 0xD5 then 0xAA with no rd_ack -> data_out=0xAA, data_valid=1, overrun=1; repeat with rd_ack on the completion cycle of 0xAA -> overrun=0.
- Pulse jitter: pulses at +-CELL_CYCLES/4 from nominal centre for 0x96 -> data_out=0x96; rd_pulse on cell-end cycle -> no extra shift.
- enable dropped after 4 bits of 0xFF, then raised and 0xB7 streamed -> data_out=0xB7 (partial bits flushed); data_valid/data_out from before the drop retained during enable=0.
- With DISK_SYNC_DETECT_EN: five 0xFF nibbles -> sync_lock=1 after the 4th; then 0xD5 -> sync_lock=0. Without the macro -> sync_lock stays 0.
